// File: rtl/mapu_pkg.sv
// Shared constants and row type for the MAPU row packer.
package mapu_pkg;
  localparam int MAPU_ROW_ELEMS  = 4;
  localparam int MAPU_MAT_ROWS   = 4;
  localparam int MAPU_DATA_WIDTH = 32;
  localparam int MAPU_CNT_W      = $clog2(MAPU_ROW_ELEMS);
  localparam int MAPU_RCNT_W     = $clog2(MAPU_MAT_ROWS);

  // One packed row; element 0 sits in index 0.
  typedef logic [MAPU_ROW_ELEMS-1:0][MAPU_DATA_WIDTH-1:0] mapu_row_t;
endpackage

// File: rtl/mapu_row_reg.sv
// Output row register with valid flag; holds contents while the consumer stalls.
module mapu_row_reg
  import mapu_pkg::*;
#(
  parameter int DATA_WIDTH = MAPU_DATA_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      load,
  input  logic                                      i_rdy,
  input  logic [MAPU_ROW_ELEMS-1:0][DATA_WIDTH-1:0] row_in,
  output logic [MAPU_ROW_ELEMS-1:0][DATA_WIDTH-1:0] row,
  output logic                                      full,
  output logic                                      xfer
);
  logic full_reg;
  logic full_next;

  assign xfer = full_reg && i_rdy;
  assign full = full_reg;

  // A load on the same edge as a transfer keeps the flag set with the new row.
  always_comb begin
    full_next = full_reg;
    if (load) begin
      full_next = 1'b1;
    end else if (xfer) begin
      full_next = 1'b0;
    end
  end

  // Valid flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_reg <= 1'b0;
    end else begin
      full_reg <= full_next;
    end
  end

  generate
    for (genvar gi = 0; gi < MAPU_ROW_ELEMS; gi++) begin : g_elem
      logic [DATA_WIDTH-1:0] elem_reg;
      // Element only changes on load, so it is stable while stalled.
      always_ff @(posedge clk) begin
        if (reset) begin
          elem_reg <= '0;
        end else if (load) begin
          elem_reg <= row_in[gi];
        end
      end
      assign row[gi] = elem_reg;
    end
  endgenerate
endmodule

// File: rtl/mapu_row_packer.sv
// Packs a serial row-major element stream into 4-element rows for the MAPU.
// Optional feature: MAPU_ROW_PACKER_PAD_EN adds i_last, which closes a short
// row early and zero-fills the remaining slots.
module mapu_row_packer
  import mapu_pkg::*;
#(
  parameter int DATA_WIDTH = MAPU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_data,
`ifdef MAPU_ROW_PACKER_PAD_EN
  input  logic                  i_last,
`endif
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_r0,
  output logic [DATA_WIDTH-1:0] o_r1,
  output logic [DATA_WIDTH-1:0] o_r2,
  output logic [DATA_WIDTH-1:0] o_r3,
  output logic                  o_mat_last
);
  localparam logic [MAPU_CNT_W-1:0]  ECNT_LAST = MAPU_CNT_W'(MAPU_ROW_ELEMS - 1);
  localparam logic [MAPU_RCNT_W-1:0] RCNT_LAST = MAPU_RCNT_W'(MAPU_MAT_ROWS - 1);

  logic [MAPU_CNT_W-1:0]  ecnt_reg, ecnt_next;
  logic [MAPU_RCNT_W-1:0] rcnt_reg, rcnt_next;
  logic                   accept;
  logic                   pad_last;
  logic                   row_done;
  logic                   ofull;
  logic                   xfer;
  logic [MAPU_ROW_ELEMS-1:0][DATA_WIDTH-1:0] row_next;
  logic [MAPU_ROW_ELEMS-1:0][DATA_WIDTH-1:0] row_q;

`ifdef MAPU_ROW_PACKER_PAD_EN
  assign pad_last = i_last;
`else
  assign pad_last = 1'b0;
`endif

  // Stall only when completing a row would overwrite a pending one; i_rdy is
  // deliberately not used here. A padded early close also completes a row.
  assign o_rdy    = i_en && !reset && !(ofull && (ecnt_reg == ECNT_LAST || pad_last));
  assign accept   = i_vld && o_rdy;
  assign row_done = accept && (ecnt_reg == ECNT_LAST || pad_last);

  generate
    for (genvar gi = 0; gi < MAPU_ROW_ELEMS; gi++) begin : g_asm
      if (gi < MAPU_ROW_ELEMS - 1) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_reg;
        // Capture the element addressed by the current element count.
        always_ff @(posedge clk) begin
          if (reset) begin
            slot_reg <= '0;
          end else if (accept && ecnt_reg == MAPU_CNT_W'(gi)) begin
            slot_reg <= i_data;
          end
        end
        // Earlier slots come from storage, the current one bypasses i_data,
        // later ones are zero (only reachable through an early close).
        assign row_next[gi] = (MAPU_CNT_W'(gi) < ecnt_reg)  ? slot_reg :
                              (MAPU_CNT_W'(gi) == ecnt_reg) ? i_data   : '0;
      end else begin : g_tail
        assign row_next[gi] = (ecnt_reg == ECNT_LAST) ? i_data : '0;
      end
    end
  endgenerate

  // Element and row counters advance on acceptance and on row transfer.
  always_comb begin
    ecnt_next = ecnt_reg;
    rcnt_next = rcnt_reg;
    if (accept) begin
      ecnt_next = row_done ? '0 : ecnt_reg + 1'b1;
    end
    if (xfer) begin
      rcnt_next = rcnt_reg + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ecnt_reg <= '0;
      rcnt_reg <= '0;
    end else begin
      ecnt_reg <= ecnt_next;
      rcnt_reg <= rcnt_next;
    end
  end

  mapu_row_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_row_reg (
    .clk   (clk),
    .reset (reset),
    .load  (row_done),
    .i_rdy (i_rdy),
    .row_in(row_next),
    .row   (row_q),
    .full  (ofull),
    .xfer  (xfer)
  );

  assign o_vld      = ofull;
  assign o_r0       = row_q[0];
  assign o_r1       = row_q[1];
  assign o_r2       = row_q[2];
  assign o_r3       = row_q[3];
  assign o_mat_last = ofull && (rcnt_reg == RCNT_LAST);
endmodule

// File: tb/tb_mapu_row_packer.sv
// Self-checking bench for mapu_row_packer against a queue-based row model.
module tb_mapu_row_packer;
  import mapu_pkg::*;

`ifdef MAPU_ROW_PACKER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_en = 1'b0;
  logic        i_vld = 1'b0;
  logic        o_rdy;
  logic [31:0] i_data = '0;
  logic        i_last = 1'b0;
  logic        o_vld;
  logic        i_rdy = 1'b0;
  logic [31:0] o_r0, o_r1, o_r2, o_r3;
  logic        o_mat_last;

  int total = 0;
  int bad   = 0;

  // Model: accepted elements of the open row, completed rows awaiting
  // transfer, and rows transferred since reset.
  logic [31:0] part[$];
  mapu_row_t   pend[$];
  int          rows_done = 0;

  always #5 clk = ~clk;

  mapu_row_packer #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_en      (i_en),
    .i_vld     (i_vld),
    .o_rdy     (o_rdy),
    .i_data    (i_data),
`ifdef MAPU_ROW_PACKER_PAD_EN
    .i_last    (i_last),
`endif
    .o_vld     (o_vld),
    .i_rdy     (i_rdy),
    .o_r0      (o_r0),
    .o_r1      (o_r1),
    .o_r2      (o_r2),
    .o_r3      (o_r3),
    .o_mat_last(o_mat_last)
  );

  // Ready rule: no element may complete a row while one is still pending.
  function automatic logic m_rdy();
    logic completes;
    completes = (part.size() == 3) || (PAD && i_last);
    return i_en && !(pend.size() > 0 && completes);
  endfunction

  function automatic logic m_last();
    return (rows_done % 4) == 3;
  endfunction

  // Apply the current inputs to the model across one rising edge.
  task automatic advance();
    logic      acc;
    logic      xf;
    mapu_row_t r;
    acc = i_vld && m_rdy();
    xf  = (pend.size() > 0) && i_rdy;
    @(posedge clk);
    if (reset) begin
      part.delete();
      pend.delete();
      rows_done = 0;
    end else begin
      if (xf) begin
        r = pend.pop_front();
        $display("row %0d xfer: %0d %0d %0d %0d", rows_done, r[0], r[1], r[2], r[3]);
        rows_done++;
      end
      if (acc) begin
        part.push_back(i_data);
        if (part.size() == 4 || (PAD && i_last)) begin
          r = '0;
          foreach (part[k]) r[k] = part[k];
          pend.push_back(r);
          part.delete();
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_en = 1'b1; i_vld = 1'b1; i_rdy = 1'b0; i_data = 32'hdead;
    advance();
    advance();
    @(negedge clk); #1;
    total++; if (o_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", o_vld); end
    total++; if (o_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", o_rdy); end
    total++; if (o_mat_last !== 1'b0) begin bad++; $display("FAIL reset_mat_last got=%b want=0", o_mat_last); end
    total++; if ({o_r3, o_r2, o_r1, o_r0} !== 128'd0) begin bad++; $display("FAIL reset_row got=%h want=0", {o_r3, o_r2, o_r1, o_r0}); end
    advance();
    @(negedge clk); reset = 1'b0; i_vld = 1'b0; i_en = 1'b1; #1;
    total++; if (o_rdy !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%b want=1", o_rdy); end
    i_en = 1'b0; #1;
    total++; if (o_rdy !== 1'b0) begin bad++; $display("FAIL reset_release_rdy_en0 got=%b want=0", o_rdy); end
    advance();
  endtask

  task automatic test_stream();
    int idx = 0;
    int cyc = 0;
    while ((idx < 16 || pend.size() > 0) && cyc < 200) begin
      @(negedge clk);
      i_en = 1'b1; i_rdy = 1'b1; i_last = 1'b0;
      i_vld = (idx < 16); i_data = 32'(idx + 1);
      #1;
      total++; if (o_rdy !== 1'b1) begin bad++; $display("FAIL stream_rdy cyc=%0d got=%b want=1", cyc, o_rdy); end
      total++; if (o_vld !== (pend.size() > 0)) begin bad++; $display("FAIL stream_vld cyc=%0d got=%b want=%b", cyc, o_vld, pend.size() > 0); end
      if (pend.size() > 0) begin
        total++;
        if ({o_r3, o_r2, o_r1, o_r0} !== pend[0] || o_mat_last !== m_last()) begin
          bad++; $display("FAIL stream_row got=%h/%b want=%h/%b", {o_r3, o_r2, o_r1, o_r0}, o_mat_last, pend[0], m_last());
        end
      end
      if (i_vld && m_rdy()) idx++;
      advance();
      cyc++;
    end
    total++; if (cyc >= 200) begin bad++; $display("FAIL stream_timeout got=%0d want<200", cyc); end
  endtask

  task automatic test_stall();
    int idx = 0;
    int cyc = 0;
    while ((idx < 8 || pend.size() > 0) && cyc < 200) begin
      @(negedge clk);
      i_en = 1'b1; i_rdy = (cyc >= 14); i_last = 1'b0;
      i_vld = (idx < 8); i_data = 32'(idx + 1);
      #1;
      total++; if (o_rdy !== m_rdy()) begin bad++; $display("FAIL stall_rdy cyc=%0d got=%b want=%b", cyc, o_rdy, m_rdy()); end
      total++; if (o_vld !== (pend.size() > 0)) begin bad++; $display("FAIL stall_vld cyc=%0d got=%b want=%b", cyc, o_vld, pend.size() > 0); end
      if (pend.size() > 0) begin
        total++;
        if ({o_r3, o_r2, o_r1, o_r0} !== pend[0] || o_mat_last !== m_last()) begin
          bad++; $display("FAIL stall_row cyc=%0d got=%h/%b want=%h/%b", cyc, {o_r3, o_r2, o_r1, o_r0}, o_mat_last, pend[0], m_last());
        end
      end
      if (i_vld && m_rdy()) idx++;
      advance();
      cyc++;
    end
    total++; if (cyc >= 200) begin bad++; $display("FAIL stall_timeout got=%0d want<200", cyc); end
  endtask

  task automatic test_enable_gap();
    int idx = 0;
    int gap = 0;
    int cyc = 0;
    while ((idx < 4 || pend.size() > 0) && cyc < 200) begin
      @(negedge clk);
      i_en = !(idx == 2 && gap < 5); i_rdy = 1'b1; i_last = 1'b0;
      i_vld = (idx < 4); i_data = 32'(idx + 1);
      if (!i_en) gap++;
      #1;
      total++; if (o_rdy !== m_rdy()) begin bad++; $display("FAIL gap_rdy cyc=%0d got=%b want=%b", cyc, o_rdy, m_rdy()); end
      total++; if (o_vld !== (pend.size() > 0)) begin bad++; $display("FAIL gap_vld cyc=%0d got=%b want=%b", cyc, o_vld, pend.size() > 0); end
      if (pend.size() > 0) begin
        total++;
        if ({o_r3, o_r2, o_r1, o_r0} !== pend[0] || o_mat_last !== m_last()) begin
          bad++; $display("FAIL gap_row got=%h/%b want=%h/%b", {o_r3, o_r2, o_r1, o_r0}, o_mat_last, pend[0], m_last());
        end
      end
      if (i_vld && m_rdy()) idx++;
      advance();
      cyc++;
    end
    total++; if (cyc >= 200 || gap != 5) begin bad++; $display("FAIL gap_done got=%0d/%0d want<200/5", cyc, gap); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] seq[6] = '{32'd1, 32'd2, 32'd9, 32'd10, 32'd11, 32'd12};
    int  idx = 0;
    int  cyc = 0;
    bit  did_reset = 1'b0;
    while ((idx < 6 || pend.size() > 0) && cyc < 200) begin
      @(negedge clk);
      i_en = 1'b1; i_rdy = 1'b1; i_last = 1'b0;
      reset = (idx == 2 && !did_reset);
      if (reset) did_reset = 1'b1;
      i_vld = (idx < 6) && !reset; i_data = (idx < 6) ? seq[idx] : '0;
      #1;
      total++;
      if (o_rdy !== (reset ? 1'b0 : m_rdy())) begin
        bad++; $display("FAIL rstmid_rdy cyc=%0d got=%b want=%b", cyc, o_rdy, reset ? 1'b0 : m_rdy());
      end
      total++; if (o_vld !== (pend.size() > 0)) begin bad++; $display("FAIL rstmid_vld cyc=%0d got=%b want=%b", cyc, o_vld, pend.size() > 0); end
      if (pend.size() > 0) begin
        total++;
        if ({o_r3, o_r2, o_r1, o_r0} !== pend[0] || o_mat_last !== m_last()) begin
          bad++; $display("FAIL rstmid_row got=%h/%b want=%h/%b", {o_r3, o_r2, o_r1, o_r0}, o_mat_last, pend[0], m_last());
        end
      end
      if (i_vld && m_rdy()) idx++;
      advance();
      cyc++;
    end
    @(negedge clk); reset = 1'b0;
    total++; if (rows_done != 1 || cyc >= 200) begin bad++; $display("FAIL rstmid_rows got=%0d want=1", rows_done); end
  endtask

`ifdef MAPU_ROW_PACKER_PAD_EN
  task automatic test_pad();
    logic [31:0] seq[6] = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    int idx = 0;
    int cyc = 0;
    int start_rows = rows_done;
    while ((idx < 6 || pend.size() > 0) && cyc < 200) begin
      @(negedge clk);
      i_en = 1'b1; i_rdy = 1'b1;
      i_vld = (idx < 6); i_data = (idx < 6) ? seq[idx] : '0; i_last = (idx == 1);
      #1;
      total++; if (o_rdy !== m_rdy()) begin bad++; $display("FAIL pad_rdy cyc=%0d got=%b want=%b", cyc, o_rdy, m_rdy()); end
      total++; if (o_vld !== (pend.size() > 0)) begin bad++; $display("FAIL pad_vld cyc=%0d got=%b want=%b", cyc, o_vld, pend.size() > 0); end
      if (pend.size() > 0) begin
        total++;
        if ({o_r3, o_r2, o_r1, o_r0} !== pend[0] || o_mat_last !== m_last()) begin
          bad++; $display("FAIL pad_row got=%h/%b want=%h/%b", {o_r3, o_r2, o_r1, o_r0}, o_mat_last, pend[0], m_last());
        end
      end
      if (i_vld && m_rdy()) idx++;
      advance();
      cyc++;
    end
    i_last = 1'b0;
    total++; if (rows_done - start_rows != 2) begin bad++; $display("FAIL pad_rows got=%0d want=2", rows_done - start_rows); end
  endtask
`endif

  task automatic test_random_matrices();
    int idx = 0;
    int cyc = 0;
    int mat_cnt = 0;
    @(negedge clk); reset = 1'b1; i_vld = 1'b0;
    advance();
    @(negedge clk); reset = 1'b0;
    while ((idx < 80 || pend.size() > 0 || part.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      i_en = ($urandom_range(9) != 0); i_rdy = $urandom_range(1); i_last = 1'b0;
      i_vld = (idx < 80) && ($urandom_range(9) < 7); i_data = $urandom;
      #1;
      total++; if (o_rdy !== m_rdy()) begin bad++; $display("FAIL rand_rdy cyc=%0d got=%b want=%b", cyc, o_rdy, m_rdy()); end
      total++; if (o_vld !== (pend.size() > 0)) begin bad++; $display("FAIL rand_vld cyc=%0d got=%b want=%b", cyc, o_vld, pend.size() > 0); end
      if (pend.size() > 0) begin
        total++;
        if ({o_r3, o_r2, o_r1, o_r0} !== pend[0] || o_mat_last !== m_last()) begin
          bad++; $display("FAIL rand_row cyc=%0d got=%h/%b want=%h/%b", cyc, {o_r3, o_r2, o_r1, o_r0}, o_mat_last, pend[0], m_last());
        end
      end
      if (o_vld && i_rdy && o_mat_last) mat_cnt++;
      if (i_vld && m_rdy()) idx++;
      advance();
      cyc++;
    end
    total++; if (mat_cnt != 5) begin bad++; $display("FAIL rand_mat_last_count got=%0d want=5", mat_cnt); end
    total++; if (rows_done != 20 || cyc >= 3000) begin bad++; $display("FAIL rand_rows got=%0d want=20", rows_done); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_enable_gap();
    test_reset_mid();
`ifdef MAPU_ROW_PACKER_PAD_EN
    test_pad();
`endif
    test_random_matrices();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
